eq_gain_sequencer: RTL and testbench
====================================

Name: eq_gain_sequencer

Overview:
- Time-multiplexes one shared 24-bit shift amplifier across NBANDS equaliser band outputs.
- Captures a frame of band samples and issues them one per cycle to the amplifier, each with that band's rate code.
- Collects the amplified results in order and presents them as one output frame.
- Holds per-band target gains written by the config path. Ramps the applied gains one step per frame towards their targets, so gain changes produce no zipper noise.

Parameters:
NBANDS, 8, number of bands sharing the amplifier (2..16)
DW, 24, sample width; must equal the amplifier data width
RAMP, 1, 1 = step applied gain by 1 per frame toward target; 0 = apply target at the next frame boundary

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cfg_we_i  in  1  target gain write strobe
cfg_band_i  in  $clog2(NBANDS)  band index for write
cfg_rate_i  in  8  target rate code: bit7=1 left shift (boost), bit7=0 right shift (cut), [6:0]=shift amount
frame_valid_i  in  1  input frame present
frame_data_i  in  NBANDS*DW  band samples, band b at [b*DW +: DW]
frame_ready_o  out  1  frame accepted on edge where valid&ready
amp_data_o  out  DW  sample to amplifier
amp_rate_o  out  8  rate code to amplifier
amp_ena_o  out  1  amplifier enable / issue strobe
amp_data_i  in  DW  amplifier result
amp_ena_i  in  1  amplifier result valid
out_data_o  out  NBANDS*DW  amplified frame, same packing as input
out_valid_o  out  1  one-cycle pulse, out_data_o updated
busy_o  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values:
  - All outputs 0, except frame_ready_o=1 (IDLE).
  - All target and current gains 0, i.e. rate 0x00 = unity.
  - Counters 0.
- Gain representation: signed integer g in -24..+24.
  - Write: mag = min(cfg_rate_i[6:0], 24); g = cfg_rate_i[7] ? +mag : -mag. Codes 0x00 and 0x80 both map to g=0.
  - Issue: g>0 -> rate {1, g[6:0]}; g<=0 -> rate {0, (-g)[6:0]}.
  - Clamping to 24 leaves amplifier results unchanged (≥24 right shift = 0; left shift of nonzero by ≥24 saturates).
- Config: a write with cfg_we_i=1 updates target[cfg_band_i] on that edge, in any state. A write with cfg_band_i >= NBANDS is ignored. Writes never change the current gains directly.
- FSM:
  - IDLE: frame_ready_o=1. On frame_valid_i=1, capture frame_data_i, clear issue/response counters, go to ISSUE.
  - ISSUE: one band per cycle, index 0..NBANDS-1. amp_ena_o=1, amp_data_o=captured[idx], amp_rate_o=encode(cur[idx]), all registered. After band NBANDS-1 is issued, go to DRAIN.
  - DRAIN: amp_ena_o=0. Wait until the response count reaches NBANDS.
  - DONE (one cycle):
    - out_data_o <= collected buffer; out_valid_o=1.
    - Gain update, every band: if RAMP, cur moves 1 toward target; else cur <= target.
    - Go to IDLE.
- Responses: every cycle in ISSUE/DRAIN with amp_ena_i=1 writes amp_data_i into buffer[resp_cnt] and increments resp_cnt. Responses are in issue order; the amplifier latency is not assumed. amp_ena_i in IDLE or DONE is ignored.
- Latency (amplifier latency 1, accept edge = 0):
  - Issues at edges 1..NBANDS.
  - Responses sampled at edges 2..NBANDS+1.
  - out_valid_o high in the cycle after edge NBANDS+1.
  - Next accept at the earliest at edge NBANDS+3.
- Gain-set consistency: a frame always uses the gains current at acceptance. A target write in the DONE cycle is stored, but that DONE step uses the old target.
- out_data_o holds its value until the next DONE.
- frame_valid_i while not in IDLE: ignored (ready low). Upstream holds data until accepted.
- Reset mid-frame: returns to IDLE and discards the partial frame and buffer. Outputs, targets and current gains return to their reset values.

Test Plan:
- Reset, no writes, NBANDS=8. Frame with band b = 0x000100*(b+1) -> out_data_o identical to the input; amp_rate_o=0x00 on every issue; out_valid_o pulses exactly once, in the cycle after edge 9.
- Write band0 target 0x82 (+2), data 0x000100; 4 frames, RAMP=1 -> band0 out 0x000100, 0x000200, 0x000400, 0x000400; amp_rate_o sequence 0x00, 0x81, 0x82, 0x82.
- Write band1 target 0x03 (-3), data 0x000800; 4 frames -> band1 out 0x000800, 0x000400, 0x000200, 0x000100. Same test with RAMP=0 -> 0x000100 from frame 1.
- Write band2 0x9F: with RAMP=0, data 0x000001 -> 0xFFFFFF and amp_rate_o=0x98. Write band2 0x1F -> frame output 0x000000, amp_rate_o=0x18. Write cfg_band_i=NBANDS -> no target changes.
- Hold frame_valid_i high continuously -> frame_ready_o low from edge 1 to DONE; accepts every NBANDS+3 cycles. Cfg write during ISSUE does not alter the in-flight frame's amp_rate_o. Wrapper with an amplifier of latency 3 -> same results, out_valid_o two cycles later.
- Assert rst_i during ISSUE at band 4 -> next cycle: IDLE, frame_ready_o=1, out_valid_o=0, gains 0. Next frame passes through at unity.

Source files
------------

// File: rtl/eq_gain_sequencer_if.sv
// eq_gain_sequencer_if: config, frame and shared-amplifier signals of the gain sequencer.
interface eq_gain_sequencer_if #(
    parameter int NBANDS = 8,
    parameter int DW     = 24
);
    logic                      cfg_we_i;
    logic [$clog2(NBANDS)-1:0] cfg_band_i;
    logic [7:0]                cfg_rate_i;
    logic                      frame_valid_i;
    logic [NBANDS*DW-1:0]      frame_data_i;
    logic                      frame_ready_o;
    logic [DW-1:0]             amp_data_o;
    logic [7:0]                amp_rate_o;
    logic                      amp_ena_o;
    logic [DW-1:0]             amp_data_i;
    logic                      amp_ena_i;
    logic [NBANDS*DW-1:0]      out_data_o;
    logic                      out_valid_o;
    logic                      busy_o;
    modport master (
        input  cfg_we_i, cfg_band_i, cfg_rate_i, frame_valid_i, frame_data_i, amp_data_i, amp_ena_i,
        output frame_ready_o, amp_data_o, amp_rate_o, amp_ena_o, out_data_o, out_valid_o, busy_o
    );
    modport slave (
        output cfg_we_i, cfg_band_i, cfg_rate_i, frame_valid_i, frame_data_i, amp_data_i, amp_ena_i,
        input  frame_ready_o, amp_data_o, amp_rate_o, amp_ena_o, out_data_o, out_valid_o, busy_o
    );
endinterface

// File: rtl/eq_gain_sequencer.sv
// eq_gain_sequencer: shares one shift amplifier across NBANDS bands, stepping each
// band's applied gain toward its configured target once per frame.
module eq_gain_sequencer #(
    parameter int NBANDS = 8,
    parameter int DW     = 24,
    parameter int RAMP   = 1
) (
    input logic                 clk_i,
    input logic                 rst_i,
    eq_gain_sequencer_if.master bus
);
    localparam int IW = $clog2(NBANDS);
    localparam int CW = $clog2(NBANDS + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t               state_q, state_d;
    logic [DW-1:0]        cap_q [NBANDS];
    logic [DW-1:0]        res_q [NBANDS];
    logic signed [5:0]    tgt_q [NBANDS];
    logic signed [5:0]    cur_q [NBANDS];
    logic [IW-1:0]        idx_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 resp, accept, cfg_ok;
    logic [NBANDS*DW-1:0] res_d;

    // Gains are signed shift counts clamped to +-24, beyond which the amplifier result no longer changes.
    function automatic logic signed [5:0] decode(input logic [7:0] r);
        logic [5:0] mag;
        mag = r[6:0] > 7'd24 ? 6'd24 : r[5:0];
        return r[7] ? $signed(mag) : -$signed(mag);
    endfunction
    function automatic logic [7:0] encode(input logic signed [5:0] g);
        return g > 6'sd0 ? {1'b1, 7'(g)} : {1'b0, 7'(-g)};
    endfunction
    function automatic logic signed [5:0] step(input logic signed [5:0] cur, input logic signed [5:0] tgt);
        return cur + (tgt > cur ? 6'sd1 : (tgt < cur ? -6'sd1 : 6'sd0));
    endfunction

    assign accept            = state_q == IDLE && bus.frame_valid_i;
    assign cfg_ok            = bus.cfg_we_i && {1'b0, bus.cfg_band_i} < (IW + 1)'(NBANDS);
    assign bus.frame_ready_o = state_q == IDLE;
    assign bus.busy_o        = state_q != IDLE;

    always_comb begin
        resp  = bus.amp_ena_i && (state_q == ISSUE || state_q == DRAIN) && cnt_q < CW'(NBANDS);
        cnt_d = cnt_q + CW'(resp);
        res_d = '0;
        for (int b = 0; b < NBANDS; b++)
            res_d[b*DW +: DW] = (resp && cnt_q == CW'(b)) ? bus.amp_data_i : res_q[b];
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.frame_valid_i ? ISSUE : IDLE;
            ISSUE:   state_d = idx_q == IW'(NBANDS - 1) ? DRAIN : ISSUE;
            DRAIN:   state_d = cnt_d == CW'(NBANDS) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            cnt_q           <= '0;
            bus.amp_data_o  <= '0;
            bus.amp_rate_o  <= '0;
            bus.amp_ena_o   <= 1'b0;
            bus.out_data_o  <= '0;
            bus.out_valid_o <= 1'b0;
            for (int b = 0; b < NBANDS; b++) begin
                cap_q[b] <= '0;
                res_q[b] <= '0;
                tgt_q[b] <= '0;
                cur_q[b] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= accept ? '0 : cnt_d;
            idx_q         <= accept ? '0 : (state_q == ISSUE ? idx_q + 1'b1 : idx_q);
            bus.amp_ena_o <= state_q == ISSUE;
            if (state_q == ISSUE) begin
                bus.amp_data_o <= cap_q[idx_q];
                bus.amp_rate_o <= encode(cur_q[idx_q]);
            end
            // Output frame includes the response landing on the same edge that enters DONE.
            bus.out_valid_o <= state_d == DONE;
            if (state_d == DONE) bus.out_data_o <= res_d;
            for (int b = 0; b < NBANDS; b++) begin
                res_q[b] <= res_d[b*DW +: DW];
                if (accept) cap_q[b] <= bus.frame_data_i[b*DW +: DW];
                if (state_q == DONE) cur_q[b] <= RAMP != 0 ? step(cur_q[b], tgt_q[b]) : tgt_q[b];
            end
            if (cfg_ok) tgt_q[bus.cfg_band_i] <= decode(bus.cfg_rate_i);
        end
    end
endmodule

// File: tb/tb_eq_gain_sequencer.sv
// tb_eq_gain_sequencer: directed checks of an 8-band ramping instance and a 6-band
// direct-apply instance, each driving a behavioural shift amplifier.
module tb_eq_gain_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eq_gain_sequencer_if #(.NBANDS(8), .DW(24)) ia ();
    eq_gain_sequencer_if #(.NBANDS(6), .DW(24)) ib ();
    eq_gain_sequencer #(.NBANDS(8), .DW(24), .RAMP(1)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ia.master));
    eq_gain_sequencer #(.NBANDS(6), .DW(24), .RAMP(0)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ib.master));

    function automatic logic [23:0] shamp(input logic [23:0] d, input logic [7:0] r);
        logic [63:0] t;
        int s;
        s = int'(r[6:0]);
        if (!r[7]) return s >= 24 ? 24'd0 : d >> s;
        if (d == 24'd0) return 24'd0;
        if (s >= 24) return 24'hFFFFFF;
        t = {40'd0, d} << s;
        return t[63:24] != 40'd0 ? 24'hFFFFFF : t[23:0];
    endfunction

    // Instance A sees a single-cycle amplifier; instance B can add two pipeline stages.
    int lat_b = 1;
    logic p1e = 1'b0, p2e = 1'b0;
    logic [23:0] p1d = '0, p2d = '0;
    always @(posedge clk) begin
        p1e <= ib.amp_ena_o;
        p1d <= shamp(ib.amp_data_o, ib.amp_rate_o);
        p2e <= p1e;
        p2d <= p1d;
    end
    assign ia.amp_ena_i  = ia.amp_ena_o;
    assign ia.amp_data_i = shamp(ia.amp_data_o, ia.amp_rate_o);
    assign ib.amp_ena_i  = lat_b == 3 ? p2e : ib.amp_ena_o;
    assign ib.amp_data_i = lat_b == 3 ? p2d : shamp(ib.amp_data_o, ib.amp_rate_o);

    int checks = 0, passed = 0;
    int n_iss, n_ov, ov_at;
    logic [7:0] rates [8];
    logic [191:0] od;

    function automatic logic [191:0] pat();
        logic [191:0] p;
        for (int b = 0; b < 8; b++) p[b*24 +: 24] = 24'(32'h100 * (b + 1));
        return p;
    endfunction

    task automatic set_frame(input bit sel, input logic v, input logic [191:0] d);
        if (sel) begin ib.frame_valid_i = v; ib.frame_data_i = d[143:0]; end
        else begin ia.frame_valid_i = v; ia.frame_data_i = d; end
    endtask

    task automatic set_cfg(input bit sel, input logic we, input logic [2:0] band, input logic [7:0] rate);
        if (sel) begin ib.cfg_we_i = we; ib.cfg_band_i = band; ib.cfg_rate_i = rate; end
        else begin ia.cfg_we_i = we; ia.cfg_band_i = band; ia.cfg_rate_i = rate; end
    endtask

    task automatic write_cfg(input bit sel, input logic [2:0] band, input logic [7:0] rate);
        set_cfg(sel, 1'b1, band, rate);
        @(negedge clk);
        set_cfg(sel, 1'b0, band, rate);
    endtask

    // Offers one frame, then watches 20 cycles; c counts edges after the accept edge.
    task automatic run_frame(input bit sel, input logic [191:0] d, input int wr_at,
                             input logic [2:0] wr_band, input logic [7:0] wr_rate);
        int t = 0;
        set_frame(sel, 1'b1, d);
        while (!(sel ? ib.frame_ready_o : ia.frame_ready_o) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            $display("FAIL accept_timeout sel=%0d frame_ready_o stayed 0, required 1", sel);
        end
        @(negedge clk);
        set_frame(sel, 1'b0, d);
        n_iss = 0; n_ov = 0; ov_at = 0; od = '0;
        for (int i = 0; i < 8; i++) rates[i] = 8'hEE;
        for (int c = 1; c <= 20; c++) begin
            if (c == wr_at) set_cfg(sel, 1'b1, wr_band, wr_rate);
            @(negedge clk);
            if (c == wr_at) set_cfg(sel, 1'b0, wr_band, wr_rate);
            if ((sel ? ib.amp_ena_o : ia.amp_ena_o) && n_iss < 8) begin
                rates[n_iss] = sel ? ib.amp_rate_o : ia.amp_rate_o;
                n_iss++;
            end
            if (sel ? ib.out_valid_o : ia.out_valid_o) begin
                n_ov++;
                ov_at = c;
                od = sel ? {48'd0, ib.out_data_o} : ia.out_data_o;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ia.frame_ready_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", ia.frame_ready_o); else passed++;
        checks++; if ({ia.busy_o, ia.out_valid_o, ia.amp_ena_o} !== 3'b000)
            $display("FAIL reset_flags busy/out_valid/amp_ena got %b exp 000", {ia.busy_o, ia.out_valid_o, ia.amp_ena_o}); else passed++;
        checks++; if ({ia.out_data_o, ia.amp_data_o, ia.amp_rate_o} !== '0)
            $display("FAIL reset_data got %h exp 0", {ia.out_data_o, ia.amp_data_o, ia.amp_rate_o}); else passed++;
        checks++; if ({ib.frame_ready_o, ib.busy_o} !== 2'b10)
            $display("FAIL reset_b ready/busy got %b exp 10", {ib.frame_ready_o, ib.busy_o}); else passed++;
    endtask

    task automatic test_unity();
        logic [7:0] ror = '0;
        run_frame(0, pat(), 0, 3'd0, 8'h00);
        for (int i = 0; i < 8; i++) ror = ror | rates[i];
        checks++; if (od !== pat()) $display("FAIL unity_data got %h exp %h", od, pat()); else passed++;
        checks++; if (n_iss !== 8) $display("FAIL unity_issues got %0d exp 8", n_iss); else passed++;
        checks++; if (ror !== 8'h00) $display("FAIL unity_rates or-of-rates got %h exp 00", ror); else passed++;
        checks++; if (n_ov !== 1) $display("FAIL unity_pulses got %0d exp 1", n_ov); else passed++;
        checks++; if (ov_at !== 9) $display("FAIL unity_latency got %0d exp 9", ov_at); else passed++;
    endtask

    task automatic test_ramp_boost();
        logic [23:0] eo [4] = '{24'h000100, 24'h000200, 24'h000400, 24'h000400};
        logic [7:0]  er [4] = '{8'h00, 8'h81, 8'h82, 8'h82};
        write_cfg(0, 3'd0, 8'h82);
        for (int f = 0; f < 4; f++) begin
            run_frame(0, pat(), 0, 3'd0, 8'h00);
            checks++; if (od[23:0] !== eo[f]) $display("FAIL boost_data f%0d got %h exp %h", f, od[23:0], eo[f]); else passed++;
            checks++; if (rates[0] !== er[f]) $display("FAIL boost_rate f%0d got %h exp %h", f, rates[0], er[f]); else passed++;
        end
    endtask

    task automatic test_ramp_cut();
        logic [23:0] eo [4] = '{24'h000800, 24'h000400, 24'h000200, 24'h000100};
        logic [191:0] d = pat();
        d[47:24] = 24'h000800;
        write_cfg(0, 3'd1, 8'h03);
        for (int f = 0; f < 4; f++) begin
            run_frame(0, d, 0, 3'd0, 8'h00);
            checks++; if (od[47:24] !== eo[f]) $display("FAIL cut_data f%0d got %h exp %h", f, od[47:24], eo[f]); else passed++;
        end
    endtask

    task automatic test_issue_write();
        run_frame(0, pat(), 2, 3'd3, 8'h85);
        checks++; if (rates[3] !== 8'h00) $display("FAIL inflight_rate got %h exp 00", rates[3]); else passed++;
        checks++; if (od[95:72] !== 24'h000400) $display("FAIL inflight_data got %h exp 000400", od[95:72]); else passed++;
        run_frame(0, pat(), 0, 3'd0, 8'h00);
        checks++; if (rates[3] !== 8'h81) $display("FAIL next_rate got %h exp 81", rates[3]); else passed++;
        checks++; if (od[95:72] !== 24'h000800) $display("FAIL next_data got %h exp 000800", od[95:72]); else passed++;
    endtask

    task automatic test_back_to_back();
        int acc [3] = '{0, 0, 0};
        int na = 0, low = 0;
        set_frame(0, 1'b1, pat());
        for (int k = 0; k < 60 && na < 3; k++) begin
            if (ia.frame_ready_o) begin acc[na] = k; na++; end
            else if (na == 1) low++;
            @(negedge clk);
        end
        set_frame(0, 1'b0, pat());
        checks++; if (na !== 3) $display("FAIL b2b_accepts got %0d exp 3", na); else passed++;
        checks++; if (acc[1] - acc[0] !== 11) $display("FAIL b2b_period1 got %0d exp 11", acc[1] - acc[0]); else passed++;
        checks++; if (acc[2] - acc[1] !== 11) $display("FAIL b2b_period2 got %0d exp 11", acc[2] - acc[1]); else passed++;
        checks++; if (low !== 10) $display("FAIL b2b_ready_low got %0d exp 10", low); else passed++;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] ror = '0;
        set_frame(0, 1'b1, pat());
        @(negedge clk);
        set_frame(0, 1'b0, pat());
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({ia.frame_ready_o, ia.out_valid_o, ia.busy_o, ia.amp_ena_o} !== 4'b1000)
            $display("FAIL midrst_state ready/valid/busy/ena got %b exp 1000", {ia.frame_ready_o, ia.out_valid_o, ia.busy_o, ia.amp_ena_o}); else passed++;
        rst = 1'b0;
        @(negedge clk);
        run_frame(0, pat(), 0, 3'd0, 8'h00);
        for (int i = 0; i < 8; i++) ror = ror | rates[i];
        checks++; if (od !== pat()) $display("FAIL midrst_data got %h exp %h", od, pat()); else passed++;
        checks++; if (ror !== 8'h00) $display("FAIL midrst_rates or-of-rates got %h exp 00", ror); else passed++;
    endtask

    task automatic test_noramp();
        logic [191:0] d = pat();
        d[47:24] = 24'h000800;
        write_cfg(1, 3'd1, 8'h03);
        run_frame(1, d, 0, 3'd0, 8'h00);
        checks++; if (ov_at !== 7) $display("FAIL b_latency got %0d exp 7", ov_at); else passed++;
        for (int f = 0; f < 2; f++) begin
            run_frame(1, d, 0, 3'd0, 8'h00);
            checks++; if (od[47:24] !== 24'h000100) $display("FAIL noramp_data f%0d got %h exp 000100", f, od[47:24]); else passed++;
            checks++; if (rates[1] !== 8'h03) $display("FAIL noramp_rate f%0d got %h exp 03", f, rates[1]); else passed++;
        end
    endtask

    task automatic test_clamp();
        logic [191:0] d = pat();
        d[71:48] = 24'h000001;
        write_cfg(1, 3'd2, 8'h9F);
        run_frame(1, d, 0, 3'd0, 8'h00);
        run_frame(1, d, 0, 3'd0, 8'h00);
        checks++; if (od[71:48] !== 24'hFFFFFF) $display("FAIL clamp_boost_data got %h exp FFFFFF", od[71:48]); else passed++;
        checks++; if (rates[2] !== 8'h98) $display("FAIL clamp_boost_rate got %h exp 98", rates[2]); else passed++;
        write_cfg(1, 3'd2, 8'h1F);
        run_frame(1, d, 0, 3'd0, 8'h00);
        run_frame(1, d, 0, 3'd0, 8'h00);
        checks++; if (od[71:48] !== 24'h000000) $display("FAIL clamp_cut_data got %h exp 000000", od[71:48]); else passed++;
        checks++; if (rates[2] !== 8'h18) $display("FAIL clamp_cut_rate got %h exp 18", rates[2]); else passed++;
    endtask

    task automatic test_ignored_band();
        logic [47:0] got;
        write_cfg(1, 3'd6, 8'h85);
        write_cfg(1, 3'd7, 8'h85);
        run_frame(1, pat(), 0, 3'd0, 8'h00);
        run_frame(1, pat(), 0, 3'd0, 8'h00);
        got = {rates[5], rates[4], rates[3], rates[2], rates[1], rates[0]};
        checks++; if (got !== 48'h000000180300) $display("FAIL ignored_band rates got %h exp 000000180300", got); else passed++;
    endtask

    task automatic test_latency3();
        logic [143:0] exp_d = {24'h000600, 24'h000500, 24'h000400, 24'h000000, 24'h000040, 24'h000100};
        lat_b = 3;
        repeat (3) @(negedge clk);
        run_frame(1, pat(), 0, 3'd0, 8'h00);
        checks++; if (od[143:0] !== exp_d) $display("FAIL lat3_data got %h exp %h", od[143:0], exp_d); else passed++;
        checks++; if (ov_at !== 9) $display("FAIL lat3_latency got %0d exp 9", ov_at); else passed++;
        checks++; if (n_ov !== 1) $display("FAIL lat3_pulses got %0d exp 1", n_ov); else passed++;
        lat_b = 1;
    endtask

    initial begin
        set_frame(0, 1'b0, '0);
        set_frame(1, 1'b0, '0);
        set_cfg(0, 1'b0, 3'd0, 8'h00);
        set_cfg(1, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        test_reset();
        test_unity();
        test_ramp_boost();
        test_ramp_cut();
        test_issue_write();
        test_back_to_back();
        test_reset_mid();
        test_noramp();
        test_clamp();
        test_ignored_band();
        test_latency3();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
